// File: rtl/sram_2p_bm_march_bist_if.sv
// ---------------------------------------------------------------------------
// sram_2p_bm_march_bist_if
// Bundle of every non-clock signal of the two-port bit-masked SRAM with its
// built-in March C- engine.
//   Port A / Port B : men, wen, ren, addr, din, bm (1 = bit written), dout
//   BIST            : bist_start (pulse), bist_busy, bist_done, bist_fail,
//                     bist_fail_addr, bist_fail_bits (expected ^ read)
// master = SoC / test controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface sram_2p_bm_march_bist_if #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 8
);
  logic                    a_men;
  logic                    a_wen;
  logic                    a_ren;
  logic [P_ADDR_WIDTH-1:0] a_addr;
  logic [P_DATA_WIDTH-1:0] a_din;
  logic [P_DATA_WIDTH-1:0] a_bm;
  logic [P_DATA_WIDTH-1:0] a_dout;

  logic                    b_men;
  logic                    b_wen;
  logic                    b_ren;
  logic [P_ADDR_WIDTH-1:0] b_addr;
  logic [P_DATA_WIDTH-1:0] b_din;
  logic [P_DATA_WIDTH-1:0] b_bm;
  logic [P_DATA_WIDTH-1:0] b_dout;

  logic                    bist_start;
  logic                    bist_busy;
  logic                    bist_done;
  logic                    bist_fail;
  logic [P_ADDR_WIDTH-1:0] bist_fail_addr;
  logic [P_DATA_WIDTH-1:0] bist_fail_bits;

  modport master (
    output a_men, a_wen, a_ren, a_addr, a_din, a_bm,
    output b_men, b_wen, b_ren, b_addr, b_din, b_bm,
    output bist_start,
    input  a_dout, b_dout,
    input  bist_busy, bist_done, bist_fail, bist_fail_addr, bist_fail_bits
  );

  modport slave (
    input  a_men, a_wen, a_ren, a_addr, a_din, a_bm,
    input  b_men, b_wen, b_ren, b_addr, b_din, b_bm,
    input  bist_start,
    output a_dout, b_dout,
    output bist_busy, bist_done, bist_fail, bist_fail_addr, bist_fail_bits
  );
endinterface

// File: rtl/sram_2p_bm_march_bist.sv
// ---------------------------------------------------------------------------
// sram_2p_bm_march_bist
// Two-port SRAM model (depth 2^P_ADDR_WIDTH, per-bit write mask, 1-cycle
// read latency) with an on-block March C- self-test engine.
//   i_clk   : single clock, everything on posedge
//   i_rst_n : synchronous reset, active low (array contents are kept)
//   bus     : port A / port B access signals and BIST start/status
// March: M0 up w0 (A); M1 up r0,w1; M2 up r1,w0; M3 down r0,w1;
//        M4 down r1,w0 (A); M5 up r0 (B); FLUSH; DONE.
// ---------------------------------------------------------------------------
module sram_2p_bm_march_bist #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  sram_2p_bm_march_bist_if.slave bus
);
  localparam int                      C_DEPTH     = 1 << P_ADDR_WIDTH;
  localparam logic [P_ADDR_WIDTH-1:0] C_ADDR_LAST = '1;
  localparam logic [P_DATA_WIDTH-1:0] C_ONES      = '1;
  localparam logic [P_DATA_WIDTH-1:0] C_ZERO      = '0;

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_FLUSH, S_DONE
  } state_t;

  logic [P_DATA_WIDTH-1:0] r_mem [C_DEPTH];

  state_t                  r_state, w_state_next;
  logic [P_ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic                    r_phase, w_phase_next;  // 0 = read half, 1 = write half

  logic                    w_busy, w_done, w_start;
  logic                    w_bist_a_we, w_bist_a_re, w_bist_b_re;
  logic [P_DATA_WIDTH-1:0] w_bist_wdata, w_bist_exp;
  logic                    w_rd_ones, w_up, w_elem_last;

  // Pipelined compare: what was read last cycle and what it should have been.
  logic                    r_cmp_valid, r_cmp_port_b;
  logic [P_DATA_WIDTH-1:0] r_cmp_exp;
  logic [P_ADDR_WIDTH-1:0] r_cmp_addr;
  logic [P_DATA_WIDTH-1:0] w_cmp_dout;
  logic                    w_miscompare;

  logic                    r_fail;
  logic [P_ADDR_WIDTH-1:0] r_fail_addr;
  logic [P_DATA_WIDTH-1:0] r_fail_bits;
  logic [P_DATA_WIDTH-1:0] r_a_dout, r_b_dout;

  // Effective port controls after the BIST/functional mux.
  logic                    w_a_we, w_a_re, w_b_we, w_b_re;
  logic [P_ADDR_WIDTH-1:0] w_a_addr, w_b_addr;
  logic [P_DATA_WIDTH-1:0] w_a_din, w_a_bm;
  logic [P_DATA_WIDTH-1:0] w_b_wdata, w_a_base, w_a_wdata;

  assign w_rd_ones   = (r_state == S_M2) || (r_state == S_M4);
  assign w_up        = (r_state == S_M1) || (r_state == S_M2);
  assign w_elem_last = w_up ? (r_addr == C_ADDR_LAST) : (r_addr == '0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_phase <= w_phase_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_phase_next = r_phase;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_start      = 1'b0;
    w_bist_a_we  = 1'b0;
    w_bist_a_re  = 1'b0;
    w_bist_b_re  = 1'b0;
    w_bist_wdata = C_ZERO;
    w_bist_exp   = C_ZERO;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_done = (r_state == S_DONE);
        if (bus.bist_start) begin
          w_start      = 1'b1;
          w_state_next = S_M0;
          w_addr_next  = '0;
          w_phase_next = 1'b0;
        end
      end
      S_M0: begin
        w_busy      = 1'b1;
        w_bist_a_we = 1'b1;
        if (r_addr == C_ADDR_LAST) begin
          w_state_next = S_M1;
          w_addr_next  = '0;
        end else begin
          w_addr_next = r_addr + 1'b1;
        end
      end
      S_M1, S_M2, S_M3, S_M4: begin
        w_busy = 1'b1;
        if (!r_phase) begin
          w_bist_a_re  = 1'b1;
          w_bist_exp   = w_rd_ones ? C_ONES : C_ZERO;
          w_phase_next = 1'b1;
        end else begin
          w_bist_a_we  = 1'b1;
          w_bist_wdata = w_rd_ones ? C_ZERO : C_ONES;
          w_phase_next = 1'b0;
          if (!w_elem_last) begin
            w_addr_next = w_up ? r_addr + 1'b1 : r_addr - 1'b1;
          end else begin
            // Element switch with no idle cycle; next element's start address.
            case (r_state)
              S_M1:    begin w_state_next = S_M2; w_addr_next = '0;          end
              S_M2:    begin w_state_next = S_M3; w_addr_next = C_ADDR_LAST; end
              S_M3:    begin w_state_next = S_M4; w_addr_next = C_ADDR_LAST; end
              default: begin w_state_next = S_M5; w_addr_next = '0;          end
            endcase
          end
        end
      end
      S_M5: begin
        w_busy      = 1'b1;
        w_bist_b_re = 1'b1;
        if (r_addr == C_ADDR_LAST) begin
          w_state_next = S_FLUSH;
        end else begin
          w_addr_next = r_addr + 1'b1;
        end
      end
      S_FLUSH: begin
        w_busy       = 1'b1;
        w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- ports
  // While the march runs the functional enables are blocked entirely.
  assign w_a_we   = w_busy ? w_bist_a_we : (bus.a_men & bus.a_wen);
  assign w_a_re   = w_busy ? w_bist_a_re : (bus.a_men & bus.a_ren);
  assign w_a_addr = w_busy ? r_addr : bus.a_addr;
  assign w_a_din  = w_busy ? w_bist_wdata : bus.a_din;
  assign w_a_bm   = w_busy ? C_ONES : bus.a_bm;
  assign w_b_we   = w_busy ? 1'b0 : (bus.b_men & bus.b_wen);
  assign w_b_re   = w_busy ? w_bist_b_re : (bus.b_men & bus.b_ren);
  assign w_b_addr = w_busy ? r_addr : bus.b_addr;

  // On a same-address double write, A's word is built on top of B's result so
  // bits masked by both take A, bits masked by one take that port.
  assign w_b_wdata = (r_mem[w_b_addr] & ~bus.b_bm) | (bus.b_din & bus.b_bm);
  assign w_a_base  = (w_b_we && (w_b_addr == w_a_addr)) ? w_b_wdata : r_mem[w_a_addr];
  assign w_a_wdata = (w_a_base & ~w_a_bm) | (w_a_din & w_a_bm);

  always_ff @(posedge i_clk) begin
    if (w_b_we) r_mem[w_b_addr] <= w_b_wdata;
    if (w_a_we) r_mem[w_a_addr] <= w_a_wdata;
  end

  // Read registers sample pre-write contents; they hold when not reading.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a_dout <= '0;
      r_b_dout <= '0;
    end else begin
      if (w_a_re) r_a_dout <= r_mem[w_a_addr];
      if (w_b_re) r_b_dout <= r_mem[w_b_addr];
    end
  end

  // ---------------------------------------------------------------- compare
  assign w_cmp_dout   = r_cmp_port_b ? r_b_dout : r_a_dout;
  assign w_miscompare = r_cmp_valid && (w_cmp_dout != r_cmp_exp);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cmp_valid  <= 1'b0;
      r_cmp_port_b <= 1'b0;
      r_cmp_exp    <= '0;
      r_cmp_addr   <= '0;
      r_fail       <= 1'b0;
      r_fail_addr  <= '0;
      r_fail_bits  <= '0;
    end else begin
      r_cmp_valid  <= w_bist_a_re | w_bist_b_re;
      r_cmp_port_b <= w_bist_b_re;
      r_cmp_exp    <= w_bist_exp;
      r_cmp_addr   <= r_addr;
      if (w_start) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_bits <= '0;
      end else if (w_miscompare && !r_fail) begin
        r_fail      <= 1'b1;
        r_fail_addr <= r_cmp_addr;
        r_fail_bits <= w_cmp_dout ^ r_cmp_exp;
      end
    end
  end

  assign bus.a_dout         = r_a_dout;
  assign bus.b_dout         = r_b_dout;
  assign bus.bist_busy      = w_busy;
  assign bus.bist_done      = w_done;
  assign bus.bist_fail      = r_fail;
  assign bus.bist_fail_addr = r_fail_addr;
  assign bus.bist_fail_bits = r_fail_bits;
endmodule
